// File: rtl/list_eval_core.sv
// list_eval_core: evaluates one tagged expression word (number, immediate, nil, or cons list summed as (+ ...)).
// Ports: clk_i/rst_ni clock and async active-low reset; start_i/exp_i evaluation request;
//        busy_o/done_o/err_o/err_code_o/ovf_o/val_o status and result; mem_rd_o/mem_addr_o/mem_data_i
//        single-outstanding memory read port (data valid MEM_LAT cycles after mem_rd_o); leds_o status lamps.
module list_eval_core #(
  parameter int WORD_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int TAG_W    = 3,
  parameter int MEM_LAT  = 1,
  parameter int MAX_LIST = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [WORD_W-1:0] exp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        err_code_o,
  output logic              ovf_o,
  output logic [WORD_W-1:0] val_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [WORD_W-1:0] mem_data_i,
  output logic [15:0]       leds_o
);
  localparam int XW  = ADDR_W + TAG_W;
  localparam int PAD = WORD_W - ADDR_W;
  localparam int LW  = $clog2(MEM_LAT + 1);
  localparam int EW  = $clog2(MAX_LIST + 2);
  localparam logic [TAG_W-1:0] T_NUM = 0, T_IMM = 1, T_CONS = 2, T_NIL = 3;
  localparam logic [2:0] S_IDLE = 0, S_DECODE = 1, S_RD_CONST = 2, S_RD_CAR = 3,
                         S_ELEM = 4, S_RD_ELEM = 5, S_RD_CDR = 6;
  logic [2:0]        state_q, state_d;
  logic [XW-1:0]     exp_q, exp_d, car_q, car_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [WORD_W-1:0] acc_q, acc_d, val_q, val_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [EW-1:0]     elem_q, elem_d;
  logic [2:0]        code_q, code_d;
  logic [15:0]       leds_q, leds_d;
  logic              ovf_q, ovf_d, done_q, done_d, err_q, err_d, rd_q, rd_d;
  logic [TAG_W-1:0]  exp_tag, car_tag, dat_tag;
  logic [ADDR_W-1:0] exp_idx, car_idx, dat_idx;
  logic [WORD_W-1:0] addend;
  logic [WORD_W:0]   sum;
  logic              ok;
  logic              unused_rsvd;
  assign unused_rsvd = ^exp_i[WORD_W-1:XW];
  assign exp_tag = exp_q[XW-1:ADDR_W];
  assign exp_idx = exp_q[ADDR_W-1:0];
  assign car_tag = car_q[XW-1:ADDR_W];
  assign car_idx = car_q[ADDR_W-1:0];
  assign dat_tag = mem_data_i[XW-1:ADDR_W];
  assign dat_idx = mem_data_i[ADDR_W-1:0];
  // One adder serves both sources: an immediate car (in ELEM) or fetched element data (in RD_ELEM).
  assign addend = state_q == S_ELEM ? {{PAD{1'b0}}, car_idx} : mem_data_i;
  assign sum = {1'b0, acc_q} + {1'b0, addend};
  // The shared latency counter reaches zero exactly in the cycle the read data is valid.
  assign ok = lat_q == '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      car_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
      val_q   <= '0;
      lat_q   <= '0;
      elem_q  <= '0;
      code_q  <= '0;
      leds_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      car_q   <= car_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      val_q   <= val_d;
      lat_q   <= lat_d;
      elem_q  <= elem_d;
      code_q  <= code_d;
      leds_q  <= leds_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    car_d   = car_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    val_d   = val_q;
    elem_d  = elem_q;
    code_d  = code_q;
    leds_d  = leds_q;
    ovf_d   = ovf_q;
    lat_d   = lat_q - LW'(lat_q != '0);
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_d    = 1'b0;
    case (state_q)
      S_IDLE:
        if (start_i) begin
          exp_d   = exp_i[XW-1:0];
          acc_d   = '0;
          ovf_d   = 1'b0;
          code_d  = '0;
          elem_d  = '0;
          leds_d  = '0;
          state_d = S_DECODE;
        end
      S_DECODE:
        if (exp_tag == T_IMM || exp_tag == T_NIL) begin
          val_d  = exp_tag == T_IMM ? {{PAD{1'b0}}, exp_idx} : '0;
          done_d = 1'b1;
        end else if (exp_tag == T_NUM || exp_tag == T_CONS) begin
          rd_d    = 1'b1;
          addr_d  = exp_idx;
          ptr_d   = exp_idx;
          state_d = exp_tag == T_NUM ? S_RD_CONST : S_RD_CAR;
        end else begin
          err_d  = 1'b1;
          code_d = 3'd1;
        end
      S_RD_CONST:
        if (ok) begin
          val_d  = mem_data_i;
          done_d = 1'b1;
        end
      S_RD_CAR:
        if (ok) begin
          car_d   = mem_data_i[XW-1:0];
          state_d = S_ELEM;
        end
      S_ELEM: begin
        elem_d = elem_q + EW'(1);
        if (elem_d > EW'(MAX_LIST)) begin
          err_d  = 1'b1;
          code_d = 3'd4;
        end else if (car_tag == T_IMM) begin
          acc_d   = sum[WORD_W-1:0];
          ovf_d   = ovf_q | sum[WORD_W];
          rd_d    = 1'b1;
          addr_d  = ptr_q + ADDR_W'(1);
          state_d = S_RD_CDR;
        end else if (car_tag == T_NUM) begin
          rd_d    = 1'b1;
          addr_d  = car_idx;
          state_d = S_RD_ELEM;
        end else begin
          err_d  = 1'b1;
          code_d = 3'd2;
        end
      end
      S_RD_ELEM:
        if (ok) begin
          acc_d   = sum[WORD_W-1:0];
          ovf_d   = ovf_q | sum[WORD_W];
          rd_d    = 1'b1;
          addr_d  = ptr_q + ADDR_W'(1);
          state_d = S_RD_CDR;
        end
      S_RD_CDR:
        if (ok) begin
          if (dat_tag == T_NIL) begin
            val_d  = acc_q;
            done_d = 1'b1;
          end else if (dat_tag == T_CONS) begin
            ptr_d   = dat_idx;
            addr_d  = dat_idx;
            rd_d    = 1'b1;
            state_d = S_RD_CAR;
          end else begin
            err_d  = 1'b1;
            code_d = 3'd3;
          end
        end
      default: state_d = S_IDLE;
    endcase
    if (rd_d) lat_d = LW'(MEM_LAT);
    if (done_d || err_d) begin
      state_d = S_IDLE;
      leds_d  = done_d ? 16'h0001 : 16'hAAAA;
    end
  end
  always_comb begin
    busy_o = state_q != S_IDLE;
    leds_o = state_q > S_RD_CDR ? 16'h6666 : leds_q;
  end
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign ovf_o      = ovf_q;
  assign val_o      = val_q;
  assign mem_rd_o   = rd_q;
  assign mem_addr_o = addr_q;
endmodule

// File: tb/tb_list_eval_core.sv
// tb_list_eval_core: checks two list_eval_core instances (MEM_LAT=1/MAX_LIST=255 and MEM_LAT=3/MAX_LIST=5)
// against a behavioural list-walking model, with directed cases followed by random expressions.
module tb_list_eval_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] exp_in = '0;
  logic        busy[2], done[2], err[2], ovf[2], rd[2];
  logic [2:0]  code[2];
  logic [15:0] val[2], data[2], leds[2];
  logic [11:0] addr[2];
  logic [15:0] mem[0:4095];
  logic [15:0] pa, pb[3];
  logic [15:0] ev[2];
  logic [11:0] alloc;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  list_eval_core #(.MEM_LAT(1), .MAX_LIST(255)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .exp_i(exp_in),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .err_code_o(code[0]), .ovf_o(ovf[0]),
    .val_o(val[0]), .mem_rd_o(rd[0]), .mem_addr_o(addr[0]), .mem_data_i(data[0]), .leds_o(leds[0]));

  list_eval_core #(.MEM_LAT(3), .MAX_LIST(5)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .exp_i(exp_in),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .err_code_o(code[1]), .ovf_o(ovf[1]),
    .val_o(val[1]), .mem_rd_o(rd[1]), .mem_addr_o(addr[1]), .mem_data_i(data[1]), .leds_o(leds[1]));

  // Memory with fixed read latency; data is undefined outside the valid cycle.
  always @(posedge clk) begin
    pa    <= rd[0] ? mem[addr[0]] : 16'hxxxx;
    pb[0] <= rd[1] ? mem[addr[1]] : 16'hxxxx;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign data[0] = pa;
  assign data[1] = pb[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input int d, input string tag);
    check(tag, 64'({busy[d], done[d], err[d], code[d], ovf[d], val[d], rd[d], addr[d], leds[d]}), 64'd0);
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // Evaluate an expression straight from the language rules; timing follows from
  // one cycle to decode, LAT+1 cycles per memory read and one cycle per list element.
  function automatic void model(input logic [15:0] e, input int maxl, input int lat,
                                output bit ok, output logic [15:0] v, output logic [2:0] ecode,
                                output bit eovf, output int reads, output int cyc);
    int elems;
    logic [16:0] s;
    logic [11:0] p;
    logic [15:0] w, c;
    ok = 0; v = '0; ecode = '0; eovf = 0; reads = 0; elems = 0; s = '0;
    case (e[14:12])
      3'd1: begin ok = 1; v = {4'h0, e[11:0]}; end
      3'd3: ok = 1;
      3'd0: begin ok = 1; v = mem[e[11:0]]; reads = 1; end
      3'd2: begin
        p = e[11:0];
        reads = 1;
        while (ecode == 0 && !ok) begin
          c = mem[p];
          elems++;
          if (elems > maxl) ecode = 3'd4;
          else if (c[14:12] != 3'd0 && c[14:12] != 3'd1) ecode = 3'd2;
          else begin
            if (c[14:12] == 3'd1) s = {1'b0, s[15:0]} + {5'b0, c[11:0]};
            else begin
              reads++;
              s = {1'b0, s[15:0]} + {1'b0, mem[c[11:0]]};
            end
            eovf = eovf | s[16];
            w = mem[p + 12'd1];
            reads++;
            if (w[14:12] == 3'd3) begin ok = 1; v = s[15:0]; end
            else if (w[14:12] == 3'd2) begin p = w[11:0]; reads++; end
            else ecode = 3'd3;
          end
        end
      end
      default: ecode = 3'd1;
    endcase
    cyc = 2 + reads * (lat + 1) + elems;
  endfunction

  task automatic run(input logic [15:0] e, input int hold);
    int cyc, stop;
    bit fin[2], gd[2], b1[2], bd[2], ov[2];
    int fc[2], nrd[2], rc[2], extra[2];
    logic [11:0] ra[2];
    logic [15:0] vv[2], lv[2];
    logic [2:0] cd[2];
    bit m_ok, m_ovf;
    logic [15:0] m_v;
    logic [2:0] m_code;
    int m_reads, m_cyc;
    string p;
    for (int d = 0; d < 2; d++) begin
      fin[d] = 0; gd[d] = 0; b1[d] = 0; bd[d] = 0; ov[d] = 0;
      fc[d] = -1; nrd[d] = 0; rc[d] = -1; extra[d] = 0; ra[d] = '0; vv[d] = '0; lv[d] = '0; cd[d] = '0;
    end
    @(negedge clk);
    exp_in = e;
    start = 1'b1;
    cyc = 0;
    stop = 4000;
    while (cyc < stop) begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold) start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (cyc == 1) b1[d] = busy[d];
        if (rd[d]) begin
          if (nrd[d] == 0) begin rc[d] = cyc; ra[d] = addr[d]; end
          nrd[d]++;
        end
        if (done[d] || err[d]) begin
          if (fin[d]) extra[d]++;
          else begin
            fin[d] = 1; fc[d] = cyc; gd[d] = done[d] && !err[d];
            vv[d] = val[d]; cd[d] = code[d]; ov[d] = ovf[d]; lv[d] = leds[d]; bd[d] = busy[d];
          end
        end
      end
      if (fin[0] && fin[1] && stop == 4000) stop = cyc + 2;
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      p = d ? "B" : "A";
      model(e, d ? 5 : 255, d ? 3 : 1, m_ok, m_v, m_code, m_ovf, m_reads, m_cyc);
      check({p, "_finished"}, 64'(fin[d]), 64'd1);
      if (fin[d]) begin
        check({p, "_done_not_err"}, 64'(gd[d]), 64'(m_ok));
        check({p, "_cycle"}, 64'(fc[d]), 64'(m_cyc));
        check({p, "_val"}, 64'(vv[d]), 64'(m_ok ? m_v : ev[d]));
        check({p, "_err_code"}, 64'(cd[d]), 64'(m_code));
        check({p, "_ovf"}, 64'(ov[d]), 64'(m_ovf));
        check({p, "_leds"}, 64'(lv[d]), m_ok ? 64'h0001 : 64'hAAAA);
        check({p, "_busy_c1"}, 64'(b1[d]), 64'd1);
        check({p, "_busy_end"}, 64'(bd[d]), 64'd0);
        check({p, "_reads"}, 64'(nrd[d]), 64'(m_reads));
        check({p, "_extra_end"}, 64'(extra[d]), 64'd0);
        if (m_reads > 0) begin
          check({p, "_rd1_cycle"}, 64'(rc[d]), 64'd2);
          check({p, "_rd1_addr"}, 64'(ra[d]), 64'(e[11:0]));
        end
        if (m_ok) ev[d] = m_v;
      end
    end
  endtask

  task automatic take(output logic [11:0] a);
    a = alloc;
    alloc = (alloc >= 12'h7F0) ? 12'h100 : alloc + 12'd2;
  endtask

  task automatic build_list(input int len, input bit bad, output logic [15:0] e);
    logic [11:0] p, nx, a;
    logic [15:0] w;
    logic [2:0] t;
    int r;
    if (len == 0) e = {rb(), 3'd3, 12'($urandom)};
    else begin
      take(p);
      e = {rb(), 3'd2, p};
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(15, 0);
        if (bad && r == 0) w = {rb(), 3'($urandom_range(7, 2)), 12'($urandom)};
        else if (r < 8) w = {rb(), 3'd1, 12'($urandom)};
        else begin
          a = 12'(12'h800 + $urandom_range(2031, 0));
          mem[a] = 16'($urandom);
          w = {rb(), 3'd0, a};
        end
        mem[p] = w;
        nx = p;
        if (i == len - 1) begin
          t = 3'd3;
          if (bad && $urandom_range(15, 0) == 0) begin
            t = 3'($urandom_range(5, 0));
            if (t > 3'd1) t = t + 3'd2;
          end
          w = {rb(), t, 12'($urandom)};
        end else begin
          take(nx);
          w = {rb(), 3'd2, nx};
        end
        mem[p + 12'd1] = w;
        p = nx;
      end
    end
  endtask

  initial begin
    logic [15:0] e;
    logic [11:0] a;
    int r;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    alloc = 12'h100;
    ev[0] = '0;
    ev[1] = '0;
    repeat (3) @(negedge clk);
    check_reset(0, "A_reset");
    check_reset(1, "B_reset");
    rst_n = 1'b1;
    run(16'h1005, 1);
    mem[12'h001] = 16'hBEEF;
    run(16'h0001, 1);
    mem[12'h010] = 16'h1003; mem[12'h011] = 16'h2020;
    mem[12'h020] = 16'h0030; mem[12'h021] = 16'h3000;
    mem[12'h030] = 16'hFFFE;
    run(16'h2010, 1);
    run(16'h5000, 1);
    repeat (3) @(negedge clk);
    check("A_code_held", 64'(code[0]), 64'd1);
    mem[12'h040] = 16'h2000; mem[12'h041] = 16'h3000;
    run(16'h2040, 1);
    mem[12'h050] = 16'h1001; mem[12'h051] = 16'h0005;
    run(16'h2050, 1);
    mem[12'h060] = 16'h1001; mem[12'h061] = 16'h2060;
    run(16'h2060, 1);
    mem[12'hFFF] = 16'h1002; mem[12'h000] = 16'h3000;
    run(16'h2FFF, 1);
    run(16'h0001, 3);
    @(negedge clk);
    exp_in = 16'h1005;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check(d ? "B_b2b_done1" : "A_b2b_done1", 64'({done[d], val[d]}), 64'h1_0005);
      ev[d] = 16'h0007;
    end
    exp_in = 16'h1007;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int d = 0; d < 2; d++) check(d ? "B_b2b_busy" : "A_b2b_busy", 64'(busy[d]), 64'd1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check(d ? "B_b2b_done2" : "A_b2b_done2", 64'({done[d], val[d]}), 64'h1_0007);
    @(negedge clk);
    exp_in = 16'h2010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset(0, "A_reset_mid");
    check_reset(1, "B_reset_mid");
    repeat (3) @(negedge clk);
    check_reset(0, "A_reset_hold");
    rst_n = 1'b1;
    ev[0] = '0;
    ev[1] = '0;
    run(16'h2010, 1);
    build_list(5, 0, e);
    run(e, 1);
    build_list(6, 0, e);
    run(e, 1);
    repeat (40) begin
      r = $urandom_range(7, 0);
      case (r)
        0: e = {rb(), 3'd1, 12'($urandom)};
        1: begin
          a = 12'(12'h800 + $urandom_range(2031, 0));
          mem[a] = 16'($urandom);
          e = {rb(), 3'd0, a};
        end
        2: e = {rb(), 3'd3, 12'($urandom)};
        3: e = {rb(), 3'($urandom_range(7, 4)), 12'($urandom)};
        default: build_list($urandom_range(7, 0), 1, e);
      endcase
      run(e, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
